prime_factor_engine: RTL and testbench

//  Parametrised trial-division primality engine; next generation of the lab prime checker.

---
 rtl/prime_factor_engine_pkg.sv | 24 ++
 rtl/prime_factor_engine_sub_div.sv | 42 ++++
 rtl/prime_factor_engine.sv | 190 +++++++++++++++++++
 tb/tb_prime_factor_engine.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/prime_factor_engine_pkg.sv
// Shared definitions for the trial-division primality engine.
// Contents:
//   state_t         - FSM state encoding (IDLE, CLASSIFY, TEST, DIV, DONE)
//   WIDTH_DEFAULT   - default operand width
//   CYC_W_DEFAULT   - default width of the saturating busy-cycle counter
//   is_busy_state() - true for the states in which a test is in progress
package prime_factor_engine_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CLASSIFY = 3'd1,
        ST_TEST     = 3'd2,
        ST_DIV      = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    localparam int unsigned WIDTH_DEFAULT = 32'd10;
    localparam int unsigned CYC_W_DEFAULT = 32'd16;

    function automatic logic is_busy_state(input state_t s);
        return (s == ST_CLASSIFY) || (s == ST_TEST) || (s == ST_DIV);
    endfunction

endpackage

// File: rtl/prime_factor_engine_sub_div.sv
// Remainder datapath for the trial-division engine.
// Holds the running remainder; loads it from the candidate value and removes
// one divisor per cycle by subtraction.
// Ports:
//   clk       in   1      system clock
//   reset     in   1      synchronous active-high reset, clears the remainder
//   load      in   1      rem <= load_val
//   sub       in   1      rem <= rem - d (ignored while load is high)
//   load_val  in   WIDTH  value loaded into the remainder
//   d         in   WIDTH  current trial divisor
//   rem_ge_d  out  1      remainder still holds at least one more divisor
//   rem_zero  out  1      remainder is exactly zero
module prime_factor_engine_sub_div #(
    parameter int unsigned WIDTH = 32'd10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             sub,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] d,
    output logic             rem_ge_d,
    output logic             rem_zero
);

    logic [WIDTH-1:0] rem_r;

    // Remainder register: load, or one repeated-subtraction step.
    always_ff @(posedge clk) begin
        if (reset) begin
            rem_r <= '0;
        end else if (load) begin
            rem_r <= load_val;
        end else if (sub) begin
            rem_r <= rem_r - d;
        end
    end

    assign rem_ge_d = (rem_r >= d);
    assign rem_zero = (rem_r == '0);

endmodule

// File: rtl/prime_factor_engine.sv
// Trial-division primality engine.
// A start pulse captures num; the engine reports whether it is prime, its
// smallest factor greater than one, and how many cycles it was busy.
// Odd divisors only, stopping once d*d exceeds the value; the square is
// tracked incrementally ((d+2)^2 = d^2 + 4d + 4) so no multiplier is needed.
// Ports:
//   clk     in   1      system clock
//   reset   in   1      synchronous active-high reset; aborts a running test
//   start   in   1      request a test; honoured only in IDLE or DONE
//   num     in   WIDTH  value to test, captured when start is accepted
//   busy    out  1      test in progress
//   done    out  1      result valid, held until the next accepted start
//   prime   out  1      value is prime (valid while done)
//   factor  out  WIDTH  smallest factor > 1; the value itself if prime; 0 if < 2
//   cycles  out  CYC_W  busy cycles of the last test, saturating
module prime_factor_engine
    import prime_factor_engine_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT,
    parameter int unsigned CYC_W = CYC_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] num,
    output logic             busy,
    output logic             done,
    output logic             prime,
    output logic [WIDTH-1:0] factor,
    output logic [CYC_W-1:0] cycles
);

    // Wide enough that sq + 4d + 4 and the sq > val compare cannot overflow.
    localparam int unsigned SQ_W = 2 * WIDTH + 1;

    localparam logic [WIDTH-1:0] VAL_TWO   = WIDTH'(2);
    localparam logic [WIDTH-1:0] VAL_THREE = WIDTH'(3);
    localparam logic [SQ_W-1:0]  SQ_NINE   = SQ_W'(9);
    localparam logic [SQ_W-1:0]  SQ_FOUR   = SQ_W'(4);
    localparam logic [CYC_W-1:0] CYC_ONE   = CYC_W'(1);
    localparam logic [CYC_W-1:0] CYC_MAX   = {CYC_W{1'b1}};

    state_t           state_r, state_s;
    logic [WIDTH-1:0] val_r, val_s;
    logic [WIDTH-1:0] d_r, d_s;
    logic [SQ_W-1:0]  sq_r, sq_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic             prime_r, prime_s;
    logic [WIDTH-1:0] factor_r, factor_s;
    logic [CYC_W-1:0] cycles_r;
    logic             cyc_clr_s;
    logic             rem_load_s;
    logic             rem_sub_s;
    logic             rem_ge_d_s;
    logic             rem_zero_s;

    prime_factor_engine_sub_div #(
        .WIDTH (WIDTH)
    ) u_sub_div (
        .clk      (clk),
        .reset    (reset),
        .load     (rem_load_s),
        .sub      (rem_sub_s),
        .load_val (val_r),
        .d        (d_r),
        .rem_ge_d (rem_ge_d_s),
        .rem_zero (rem_zero_s)
    );

    // Next-state, datapath and result logic.
    always_comb begin
        state_s    = state_r;
        val_s      = val_r;
        d_s        = d_r;
        sq_s       = sq_r;
        prime_s    = prime_r;
        factor_s   = factor_r;
        cyc_clr_s  = 1'b0;
        rem_load_s = 1'b0;
        rem_sub_s  = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_s   = ST_CLASSIFY;
                    val_s     = num;
                    prime_s   = 1'b0;
                    factor_s  = '0;
                    cyc_clr_s = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end
            ST_CLASSIFY: begin
                if (val_r < VAL_TWO) begin
                    state_s  = ST_DONE;
                    prime_s  = 1'b0;
                    factor_s = '0;
                end else if ((val_r == VAL_TWO) || (val_r == VAL_THREE)) begin
                    state_s  = ST_DONE;
                    prime_s  = 1'b1;
                    factor_s = val_r;
                end else if (!val_r[0]) begin
                    state_s  = ST_DONE;
                    prime_s  = 1'b0;
                    factor_s = VAL_TWO;
                end else begin
                    state_s = ST_TEST;
                    d_s     = VAL_THREE;
                    sq_s    = SQ_NINE;
                end
            end
            ST_TEST: begin
                if (sq_r > SQ_W'(val_r)) begin
                    state_s  = ST_DONE;
                    prime_s  = 1'b1;
                    factor_s = val_r;
                end else begin
                    state_s    = ST_DIV;
                    rem_load_s = 1'b1;
                end
            end
            ST_DIV: begin
                if (rem_ge_d_s) begin
                    rem_sub_s = 1'b1;
                end else if (rem_zero_s) begin
                    state_s  = ST_DONE;
                    prime_s  = 1'b0;
                    factor_s = d_r;
                end else begin
                    state_s = ST_TEST;
                    d_s     = d_r + VAL_TWO;
                    sq_s    = sq_r + SQ_W'({d_r, 2'b00}) + SQ_FOUR;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                val_s     = '0;
                d_s       = '0;
                sq_s      = '0;
                prime_s   = 1'b0;
                factor_s  = '0;
                cyc_clr_s = 1'b1;
            end
        endcase
        busy_s = is_busy_state(state_s);
        done_s = (state_s == ST_DONE);
    end

    // State, datapath and registered result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            val_r    <= '0;
            d_r      <= '0;
            sq_r     <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            prime_r  <= 1'b0;
            factor_r <= '0;
        end else begin
            state_r  <= state_s;
            val_r    <= val_s;
            d_r      <= d_s;
            sq_r     <= sq_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
            prime_r  <= prime_s;
            factor_r <= factor_s;
        end
    end

    // Busy-cycle counter: counts every busy cycle, saturates, frozen otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycles_r <= '0;
        end else if (cyc_clr_s) begin
            cycles_r <= '0;
        end else if (busy_r && (cycles_r != CYC_MAX)) begin
            cycles_r <= cycles_r + CYC_ONE;
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign prime  = prime_r;
    assign factor = factor_r;
    assign cycles = cycles_r;

endmodule

// File: tb/tb_prime_factor_engine.sv
// Scoreboard bench for prime_factor_engine: stimulus pushes expected results,
// a monitor pops and compares on every rising edge of done.
module tb_prime_factor_engine;

    localparam int W  = 10;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [W-1:0]  num;
    logic          busy;
    logic          done;
    logic          prime;
    logic [W-1:0]  factor;
    logic [CW-1:0] cycles;

    typedef struct {
        int n;
        int p;
        int f;
        int c;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    prime_factor_engine #(
        .WIDTH (W),
        .CYC_W (CW)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .num    (num),
        .busy   (busy),
        .done   (done),
        .prime  (prime),
        .factor (factor),
        .cycles (cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: plain division/modulo plus the documented latency formula.
    function automatic void model(input int v, output int p, output int f, output int c);
        int d;
        c = 1;
        if (v < 2) begin p = 0; f = 0; return; end
        if (v == 2 || v == 3) begin p = 1; f = v; return; end
        if (v % 2 == 0) begin p = 0; f = 2; return; end
        for (d = 3; d * d <= v; d += 2) begin
            c += 1 + (v / d) + 1;
            if (v % d == 0) begin p = 0; f = d; return; end
        end
        c += 1;
        p = 1;
        f = v;
    endfunction

    task automatic wait_done(input int v);
        bit seen = 1'b0;
        for (int k = 0; k < 5000; k++) begin
            @(posedge clk); #1;
            if (done) begin seen = 1'b1; break; end
        end
        if (!seen) begin
            n_vec++;
            n_bad++;
            $display("FAIL timeout num=%0d: got no done, expected done within 5000 cycles", v);
        end
    endtask

    task automatic issue(input int v, input int ep, input int ef, input int ec);
        exp_t e;
        e.n = v; e.p = ep; e.f = ef; e.c = ec;
        @(negedge clk);
        num   = W'(v);
        start = 1'b1;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        wait_done(v);
    endtask

    task automatic issue_model(input int v);
        int p, f, c;
        model(v, p, f, c);
        issue(v, p, f, c);
    endtask

    // Monitor: counts busy cycles and scores each result as done rises.
    logic done_q   = 1'b0;
    int   busy_cnt = 0;
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (reset) begin
            busy_cnt = 0;
            done_q   = 1'b0;
        end else begin
            if (busy) busy_cnt++;
            if (done && !done_q) begin
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_done: got done with factor=%0d, expected no result", factor);
                end else begin
                    e = sb_q.pop_front();
                    check($sformatf("prime[%0d]", e.n), 32'(prime), e.p);
                    check($sformatf("factor[%0d]", e.n), 32'(factor), e.f);
                    check($sformatf("cycles[%0d]", e.n), 32'(cycles), e.c);
                    check($sformatf("latency[%0d]", e.n), busy_cnt, e.c);
                end
                busy_cnt = 0;
            end
            done_q = done;
        end
    end

    int tab_n[8] = '{0, 1, 2, 4, 7, 9, 961, 1021};
    int tab_p[8] = '{0, 0, 1, 0, 1, 0, 0, 1};
    int tab_f[8] = '{0, 0, 2, 2, 7, 3, 31, 1021};
    int tab_c[8] = '{1, 1, 1, 1, 2, 6, 0, 0};

    initial begin
        int p, f, c;
        reset = 1'b1;
        start = 1'b0;
        num   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_prime", 32'(prime), 0);
        check("reset_factor", 32'(factor), 0);
        check("reset_cycles", 32'(cycles), 0);
        @(negedge clk);
        reset = 1'b0;

        // Directed vectors; a zero cycle entry takes the count from the model.
        for (int i = 0; i < 8; i++) begin
            model(tab_n[i], p, f, c);
            issue(tab_n[i], tab_p[i], tab_f[i], (tab_c[i] != 0) ? tab_c[i] : c);
        end

        // Result held in DONE with no start.
        repeat (3) @(posedge clk);
        #1;
        check("done_held", 32'(done), 1);
        check("factor_held", 32'(factor), 1021);

        // Start while busy is ignored; num changes do not disturb the test.
        @(negedge clk);
        num = W'(9); start = 1'b1;
        sb_q.push_back('{n: 9, p: 0, f: 3, c: 6});
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        num = W'(7); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(9);

        // Restart from DONE: done drops at the accept edge.
        @(negedge clk);
        num = W'(7); start = 1'b1;
        sb_q.push_back('{n: 7, p: 1, f: 7, c: 2});
        @(posedge clk); #1;
        check("restart_done_low", 32'(done), 0);
        check("restart_busy", 32'(busy), 1);
        @(negedge clk);
        start = 1'b0;
        wait_done(7);

        // Reset during DIV aborts the test with no result.
        @(negedge clk);
        num = W'(1021); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_prime", 32'(prime), 0);
        check("abort_factor", 32'(factor), 0);
        check("abort_cycles", 32'(cycles), 0);
        @(negedge clk);
        reset = 1'b0;
        issue(5, 1, 5, 2);

        // Model sweep over the low range plus a strided sample of the upper range.
        for (int v = 0; v < 256; v++) issue_model(v);
        for (int k = 0; k < 13; k++) issue_model(256 + 61 * k);

        for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(posedge clk);
        if (sb_q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: got %0d pending results, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
